// File: rtl/imm_pack.sv
// imm_pack: packs a signed immediate into the I/S/B fields of an RV32I word, behind a 2-entry output FIFO.
// Optional feature macro: IMM_PACK_RANGE_CHECK_EN flags immediates that do not fit the selected format.
module imm_pack #(
    parameter int X_LEN = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [X_LEN-1:0] instr_i,
    input  logic [X_LEN-1:0] imm_i,
    input  logic [1:0]       IMM_SEL_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [X_LEN-1:0] instr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] enc_cnt_o
);
    logic [X_LEN-1:0] pk_instr;
    logic             pk_err;
    logic [X_LEN:0]   mem_q [2];
    logic [X_LEN:0]   mem_d [2];
    logic             rd_q, rd_d, wr_q, wr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] enc_q, enc_d;
    logic             push, pop;

`ifdef IMM_PACK_RANGE_CHECK_EN
    logic fits12, fits13, range_err;
    assign fits12    = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits13    = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign range_err = IMM_SEL_i[1] ? (!fits13 || imm_i[0]) : !fits12;
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[31:13];
`endif

    // Scatter the immediate into the format-specific bit positions; reserved select passes through flagged
    always_comb begin
        pk_instr = instr_i;
        pk_err   = 1'b0;
        case (IMM_SEL_i)
            2'b00: pk_instr[31:20] = imm_i[11:0];
            2'b01: begin
                pk_instr[31:25] = imm_i[11:5];
                pk_instr[11:7]  = imm_i[4:0];
            end
            2'b10: begin
                pk_instr[31]    = imm_i[12];
                pk_instr[7]     = imm_i[11];
                pk_instr[30:25] = imm_i[10:5];
                pk_instr[11:8]  = imm_i[4:1];
            end
            default: pk_err = 1'b1;
        endcase
`ifdef IMM_PACK_RANGE_CHECK_EN
        if (IMM_SEL_i != 2'b11 && range_err) pk_err = 1'b1;
`endif
    end

    assign ready_o   = (cnt_q != 2'd2);
    assign valid_o   = (cnt_q != 2'd0);
    assign push      = valid_i && ready_o;
    assign pop       = valid_o && ready_i;
    assign enc_cnt_o = enc_q;
    // When empty the slot behind the read pointer still holds the last popped entry
    assign {err_o, instr_o} = valid_o ? mem_q[rd_q] : mem_q[~rd_q];

    // FIFO pointer, occupancy and handshake counter next-state
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_d     = push ? ~wr_q : wr_q;
        rd_d     = pop ? ~rd_q : rd_q;
        enc_d    = pop ? enc_q + 1'b1 : enc_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) mem_d[wr_q] = {pk_err, pk_instr};
    end

    // State registers; reset discards any buffered entries
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
            enc_q    <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            enc_q    <= enc_d;
        end
    end
endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: scoreboard bench for imm_pack (directed vectors, backpressure, reset, random traffic).
module tb_imm_pack;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_o, valid_o, ready_i, err_o;
    logic [31:0] instr_i, imm_i, instr_o;
    logic [1:0]  IMM_SEL_i;
    logic [15:0] enc_cnt_o;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb [$];
    logic [32:0] exp_a, exp_c;

    imm_pack dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .imm_i(imm_i), .IMM_SEL_i(IMM_SEL_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o),
        .err_o(err_o), .enc_cnt_o(enc_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] ins, input logic [31:0] imm, input logic [1:0] sel);
        logic [31:0] r;
        logic        e;
        r = ins;
        e = 1'b0;
        if (sel == 2'b00) r = {imm[11:0], ins[19:0]};
        else if (sel == 2'b01) r = {imm[11:5], ins[24:12], imm[4:0], ins[6:0]};
        else if (sel == 2'b10) r = {imm[12], imm[10:5], ins[24:12], imm[4:1], imm[11], ins[6:0]};
        else e = 1'b1;
`ifdef IMM_PACK_RANGE_CHECK_EN
        if (sel != 2'b11 && sel != 2'b10 && $signed(imm) != $signed({{20{imm[11]}}, imm[11:0]})) e = 1'b1;
        if (sel == 2'b10 && ($signed(imm) != $signed({{19{imm[12]}}, imm[12:0]}) || imm[0])) e = 1'b1;
`endif
        return {e, r};
    endfunction

    // Scoreboard: record expectations on accept, compare on output handshake
    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o && ready_i) begin
                if (sb.size() == 0) check("sb_underrun", valid_o, 0);
                else check("sb", {err_o, instr_o}, sb.pop_front());
            end
            if (valid_i && ready_o) sb.push_back(model(instr_i, imm_i, IMM_SEL_i));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] imm, input logic [1:0] sel);
        instr_i   = ins;
        imm_i     = imm;
        IMM_SEL_i = sel;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] imm, input logic [1:0] sel);
        int n = 0;
        drive(ins, imm, sel);
        valid_i = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 50) begin
                check("send_timeout", ready_o, 1);
                break;
            end
        end
        step();
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        drive(32'h0, 32'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_instr", instr_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cnt", enc_cnt_o, 0);
        step();

        ready_i = 1'b1;
        send(32'h00000013, 32'hFFFFFFFF, 2'b00);
        @(negedge clk);
        check("i_valid", valid_o, 1);
        check("i_instr", instr_o, 32'hFFF00013);
        check("i_err", err_o, 0);
        step();
        send(32'h00002023, 32'h000007FC, 2'b01);
        @(negedge clk);
        check("s_instr", instr_o, 32'h7E002E23);
        check("s_err", err_o, 0);
        step();
        send(32'h00000063, 32'hFFFFFFFC, 2'b10);
        @(negedge clk);
        check("b_instr", instr_o, 32'hFE000EE3);
        check("b_err", err_o, 0);
        step();
        send(32'h12345678, 32'hABCDEF01, 2'b11);
        @(negedge clk);
        check("rsv_instr", instr_o, 32'h12345678);
        check("rsv_err", err_o, 1);
        step();
        send(32'h00000013, 32'h00000800, 2'b00);
        @(negedge clk);
        check("rng_field", instr_o[31:20], 12'h800);
`ifdef IMM_PACK_RANGE_CHECK_EN
        check("rng_err", err_o, 1);
`else
        check("rng_err", err_o, 0);
`endif
        step();
        check("cnt_5", enc_cnt_o, 5);

        do_reset();
        ready_i = 1'b0;
        exp_a = model(32'h00000013, 32'h00000123, 2'b00);
        exp_c = model(32'h00000063, 32'h00000010, 2'b10);
        valid_i = 1'b1;
        drive(32'h00000013, 32'h00000123, 2'b00);
        @(negedge clk);
        check("bp_rdy_a", ready_o, 1);
        step();
        drive(32'h00002023, 32'hFFFFFFF0, 2'b01);
        @(negedge clk);
        check("bp_rdy_b", ready_o, 1);
        check("bp_valid", valid_o, 1);
        step();
        drive(32'h00000063, 32'h00000010, 2'b10);
        @(negedge clk);
        check("bp_full", ready_o, 0);
        step();
        @(negedge clk);
        check("bp_stable", {err_o, instr_o}, exp_a);
        check("bp_still_full", ready_o, 0);
        step();
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_no_comb_ready", ready_o, 0);
        step();
        @(negedge clk);
        check("bp_ready_rise", ready_o, 1);
        check("bp_cnt1", enc_cnt_o, 1);
        step();
        valid_i = 1'b0;
        @(negedge clk);
        check("bp_cnt2", enc_cnt_o, 2);
        step();
        @(negedge clk);
        check("empty_valid", valid_o, 0);
        check("empty_hold", {err_o, instr_o}, exp_c);
        step();

        ready_i = 1'b0;
        send(32'h00000013, 32'h00000001, 2'b00);
        send(32'h00000013, 32'h00000002, 2'b00);
        @(negedge clk);
        check("two_buffered", ready_o, 0);
        step();
        do_reset();
        @(negedge clk);
        check("rst2_valid", valid_o, 0);
        check("rst2_ready", ready_o, 1);
        check("rst2_cnt", enc_cnt_o, 0);
        check("rst2_instr", instr_o, 0);
        step();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            valid_i = $urandom_range(0, 1);
            ready_i = ($urandom_range(0, 3) != 0);
            drive($urandom, r[31] ? r : {{19{r[12]}}, r[12:0]}, 2'($urandom_range(0, 3)));
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        check("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
